cipher_core: RTL and testbench
==============================

CIPHER_CORE -- requirements
Module: cipher_core

Interface
REQ-001: Parameters: none; fixed AES-128 (Nb=4, Nr=10).
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high; restarts the cipher, shared with keyexpansion.
REQ-004: plaintext  input  128  input block; byte 0 = bits [127:120], column-major order per FIPS-197.
REQ-005: roundKey  input  128  current round key, driven by keyexpansion wBlock; same byte order.
REQ-006: ciphertext  output  128  registered cipher state; final ciphertext once done=1.
REQ-007: done  output  1  registered; high when ciphertext is valid.

Function
REQ-008: The core SHALL keep a 128-bit state register, a 4-bit round counter and a 4-state FSM: INIT, ROUND, FINAL, DONE.
REQ-009: Round alignment SHALL be fixed: the k-th rising edge after reset deasserts (k=1..11) consumes round key k-1 from roundKey, matching keyexpansion's one-key-per-cycle output.
REQ-010: INIT, counter=0: on edge, state <= plaintext ^ roundKey; counter <= 1; go to ROUND.
REQ-011: ROUND, counter 1..9: on edge, state <= MixColumns(ShiftRows(SubBytes(state))) ^ roundKey; counter <= counter+1; go to FINAL when the counter that was used is 9.
REQ-012: FINAL, counter=10: on edge, state <= ShiftRows(SubBytes(state)) ^ roundKey, with no MixColumns; counter <= 11; done <= 1; go to DONE.
REQ-013: DONE: state, counter and done SHALL hold; roundKey and plaintext are ignored; DONE has no exit except reset.
REQ-014: plaintext SHALL be sampled only on the INIT edge; later changes SHALL NOT affect the result.
REQ-015: Latency SHALL be exactly 11 clocks from the first edge with reset low to the first cycle with done=1.
REQ-016: ciphertext SHALL equal the state register at all times; intermediate round states are visible while done=0.
REQ-017: SubBytes SHALL use the FIPS-197 S-box on all 16 bytes.
REQ-018: ShiftRows SHALL rotate row r left by r bytes.
REQ-019: MixColumns SHALL use GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; all XORs are 128-bit with no carries.
REQ-020: The round datapath SHALL be a single combinational round per cycle; no multi-cycle paths.
REQ-021: The counter SHALL saturate at 11 and SHALL NOT wrap.
REQ-022: An illegal FSM encoding SHALL return to INIT on the next edge with done=0.

Reset
REQ-023: With reset high at an edge, the core SHALL set FSM=INIT, counter=0, state=128'h0 and done=0.
REQ-024: Reset asserted mid-operation, including in DONE, SHALL abort the encryption on that edge; the next edge with reset low restarts at INIT with the new plaintext.
REQ-025: When reset and any round transition coincide, reset SHALL take priority.
REQ-026: No output SHALL change asynchronously to clk.

Verification
REQ-027: FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 193de3bea0f4e22b9ac68d2ae9f84808 after edge 1, a49c7ff2689f352b6b5bea43026a5049 after edge 2, 3925841d02dc09fbdc118597196a0b32 with done=1 after edge 11.
REQ-028: FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a, done rising exactly on edge 11, done=0 on edges 1-10.
REQ-029: App. B vector, plaintext changed to all-ones after edge 1 -> ciphertext still 3925841d02dc09fbdc118597196a0b32.
REQ-030: Reset pulsed for 1 cycle after edge 5 of App. B, then C.1 vector applied -> state=0 and done=0 during reset, then 69c4e0d86a7b0430d8cdb78070b4c55a 11 edges after release.
REQ-031: Hold in DONE for 50 cycles with random roundKey and plaintext -> ciphertext and done=1 unchanged.
REQ-032: Run 1000 random key/plaintext pairs against a software AES-128 model -> all results match at edge 11, with keyexpansion instantiated alongside the core.

Source files
------------

// File: rtl/cipher_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cipher_core                                                   |
// | Brief    : AES-128 encryption core, one round per clock, key per cycle.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cipher_core (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] plaintext,
  input  logic [127:0] roundKey,
  output logic [127:0] ciphertext,
  output logic         done
);

  localparam logic [1:0] c_INIT  = 2'd0;
  localparam logic [1:0] c_ROUND = 2'd1;
  localparam logic [1:0] c_FINAL = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [3:0] c_LAST_MID = 4'd9;
  localparam logic [3:0] c_SAT_CNT  = 4'd11;

  localparam logic [7:0] c_SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [1:0]   r_fsm, w_fsm_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic         r_done, w_done_nxt;
  logic [127:0] w_sb, w_sr, w_mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign w_sb[127-8*i -: 8] = c_SBOX[r_state[127-8*i -: 8]];
  end

  for (genvar i = 0; i < 16; i++) begin : g_shift
    localparam int SRC = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
    assign w_sr[127-8*i -: 8] = w_sb[127-8*SRC -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[127-32*c -: 8];
    assign w_a1 = w_sr[119-32*c -: 8];
    assign w_a2 = w_sr[111-32*c -: 8];
    assign w_a3 = w_sr[103-32*c -: 8];
    assign w_mc[127-32*c -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
    };
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= c_INIT;
      r_round <= 4'd0;
      r_state <= 128'h0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_round <= w_round_nxt;
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = c_INIT;
    case (r_fsm)
      c_INIT:  w_fsm_nxt = c_ROUND;
      c_ROUND: w_fsm_nxt = (r_round >= c_LAST_MID) ? c_FINAL : c_ROUND;
      c_FINAL: w_fsm_nxt = c_DONE;
      c_DONE:  w_fsm_nxt = c_DONE;
      default: w_fsm_nxt = c_INIT;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_done_nxt  = r_done;
    case (r_fsm)
      c_INIT: begin
        w_state_nxt = plaintext ^ roundKey;
        w_round_nxt = 4'd1;
        w_done_nxt  = 1'b0;
      end
      c_ROUND: begin
        w_state_nxt = w_mc ^ roundKey;
        w_round_nxt = r_round + 4'd1;
      end
      c_FINAL: begin
        w_state_nxt = w_sr ^ roundKey;
        w_round_nxt = c_SAT_CNT;
        w_done_nxt  = 1'b1;
      end
      c_DONE: ;
      default: begin
        w_round_nxt = 4'd0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign ciphertext = r_state;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cipher_core.sv
`default_nettype none
// Bench for cipher_core: known-answer table, corner sequences and random
// vectors against a software AES-128 model (S-box derived from GF inverses).
module tb_cipher_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] plaintext;
  logic [127:0] roundKey;
  logic [127:0] ciphertext;
  logic         done;

  always #5 clk = ~clk;

  cipher_core dut (
    .clk        (clk),
    .reset      (reset),
    .plaintext  (plaintext),
    .roundKey   (roundKey),
    .ciphertext (ciphertext),
    .done       (done)
  );

  int n_pass;
  int n_total;

  logic [7:0]   sb   [256];
  logic [127:0] m_rk [11];
  logic [127:0] m_st [12];
  logic [127:0] obs  [12];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] e1;
    logic         has_e2;
    logic [127:0] e2;
    logic [127:0] ct;
  } vec_t;
  vec_t tbl [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: round keys in m_rk, expected state after edge k in m_st[k].
  task automatic model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc, acc;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [7:0]  coef [4];
    rc = 8'h01;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8] ^ m_rk[0][127-8*i -: 8];
      m_st[1][127-8*i -: 8] = s[i];
    end
    m_st[0] = 128'h0;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) u[r+4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], u[j+4*c]);
          s[r+4*c] = (rnd < 10) ? acc : u[r+4*c];
        end
      for (int i = 0; i < 16; i++) begin
        s[i] = s[i] ^ m_rk[rnd][127-8*i -: 8];
        m_st[rnd+1][127-8*i -: 8] = s[i];
      end
    end
  endtask

  task automatic run_enc(input logic [127:0] key, input logic [127:0] pt,
                         input bit scramble, input bit trace, input bit do_reset);
    model(key, pt);
    if (do_reset) begin
      reset = 1'b1; plaintext = rand128(); roundKey = rand128();
      @(posedge clk); #1;
      chk("reset_state", ciphertext, 128'h0);
      chk1("reset_done", done, 1'b0);
    end
    reset = 1'b0; plaintext = pt; roundKey = m_rk[0];
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      obs[k] = ciphertext;
      if (scramble) plaintext = '1;
      roundKey = (k < 11) ? m_rk[k] : rand128();
      if (trace) begin
        chk($sformatf("state_edge%0d", k), ciphertext, m_st[k]);
        chk1($sformatf("done_edge%0d", k), done, k == 11);
      end else if (k >= 10) begin
        chk1($sformatf("done_edge%0d", k), done, k == 11);
      end
    end
    chk("final_ct", obs[11], m_st[11]);
  endtask

  logic [127:0] held;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; plaintext = '0; roundKey = '0;
    build_sbox();

    tbl[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
               e1: 128'h193de3bea0f4e22b9ac68d2ae9f84808, has_e2: 1'b1,
               e2: 128'ha49c7ff2689f352b6b5bea43026a5049, ct: 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
               e1: 128'h00102030405060708090a0b0c0d0e0f0, has_e2: 1'b0,
               e2: 128'h0, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};

    for (int i = 0; i < 2; i++) begin
      run_enc(tbl[i].key, tbl[i].pt, 1'b0, 1'b1, 1'b1);
      chk($sformatf("kat%0d_edge1", i), obs[1], tbl[i].e1);
      if (tbl[i].has_e2) chk($sformatf("kat%0d_edge2", i), obs[2], tbl[i].e2);
      chk($sformatf("kat%0d_ct", i), obs[11], tbl[i].ct);
    end

    // Plaintext changes after the INIT edge must not matter.
    run_enc(tbl[0].key, tbl[0].pt, 1'b1, 1'b0, 1'b1);
    chk("pt_scramble_ct", obs[11], tbl[0].ct);

    // DONE holds regardless of inputs.
    held = ciphertext;
    for (int n = 0; n < 50; n++) begin
      plaintext = rand128(); roundKey = rand128();
      @(posedge clk); #1;
      chk("hold_ct", ciphertext, held);
      chk1("hold_done", done, 1'b1);
    end

    // Abort App. B after edge 5 with a one-cycle reset, then run C.1.
    model(tbl[0].key, tbl[0].pt);
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0; plaintext = tbl[0].pt; roundKey = m_rk[0];
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      roundKey = m_rk[k];
    end
    chk("abort_pre_edge5", ciphertext, m_st[5]);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", ciphertext, 128'h0);
    chk1("abort_done", done, 1'b0);
    run_enc(tbl[1].key, tbl[1].pt, 1'b0, 1'b1, 1'b0);
    chk("abort_restart_ct", obs[11], tbl[1].ct);

    for (int n = 0; n < 1000; n++) run_enc(rand128(), rand128(), 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
